// File: rtl/apb_cluster_boot_ctrl.sv
// APB-programmable reset/boot sequencer for NUM_CLUSTERS accelerator clusters.
// Each cluster has its own lane: release reset, count a programmable delay,
// then raise fetch enable. Sticky end-of-computation bits drive a level IRQ.
// Optional feature macro: CLUSTER_BOOT_AUTOSTART_EN (cluster 0 self-starts
// on the first clock edge after reset using the DELAY reset value).

package apb_cluster_boot_pkg;
  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } lane_state_e;

  // Decoded, already-qualified register writes for one cluster lane.
  typedef struct packed {
    logic ctrl_wr;
    logic start;
    logic stop;
    logic en_sa;
    logic delay_wr;
    logic eoc_clr;
  } lane_req_t;

  // Lane status visible on the register read path.
  typedef struct packed {
    lane_state_e state;
    logic        eoc;
    logic        en_sa;
  } lane_rsp_t;
endpackage

// One cluster: command capture, DELAY/EN_SA_BOOT/EOC registers and boot FSM.
module apb_cluster_boot_lane
  import apb_cluster_boot_pkg::*;
#(
  parameter int DELAY_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  lane_req_t          req_i,
  input  logic [DELAY_W-1:0] wdelay_i,
  input  logic               autostart_i,
  input  logic               eoc_i,
  output logic [DELAY_W-1:0] delay_o,
  output lane_rsp_t          rsp_o,
  output logic               rstn_o,
  output logic               fetch_en_o,
  output logic               en_sa_boot_o
);
  lane_state_e        state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d, delay_q;
  logic               start_q, stop_q, en_sa_q, eoc_q, rstn_q, fetch_q;

  // Capture START/STOP pulses one cycle after the write; hold R/W and sticky bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      en_sa_q <= 1'b0;
      delay_q <= DELAY_W'(16);
      eoc_q   <= 1'b0;
    end else begin
      start_q <= (req_i.ctrl_wr & req_i.start) | autostart_i;
      stop_q  <= req_i.ctrl_wr & req_i.stop;
      if (req_i.ctrl_wr)  en_sa_q <= req_i.en_sa;
      if (req_i.delay_wr) delay_q <= wdelay_i;
      // A set in the same cycle as a software clear wins.
      eoc_q   <= (eoc_i & (state_q == ST_RUN)) | (eoc_q & ~req_i.eoc_clr);
    end
  end

  // Next-state logic: STOP dominates; START only honoured from OFF.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (stop_q) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (start_q) begin
            state_d = ST_RELEASE;
            cnt_d   = delay_q;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - DELAY_W'(1);
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_OFF;
      endcase
    end
  end

  // State register plus registered pin outputs derived from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      rstn_q  <= 1'b0;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rstn_q  <= (state_d != ST_OFF);
      fetch_q <= (state_d == ST_RUN);
    end
  end

  assign delay_o      = delay_q;
  assign rsp_o.state  = state_q;
  assign rsp_o.eoc    = eoc_q;
  assign rsp_o.en_sa  = en_sa_q;
  assign rstn_o       = rstn_q;
  assign fetch_en_o   = fetch_q;
  assign en_sa_boot_o = en_sa_q;
endmodule

module apb_cluster_boot_ctrl
  import apb_cluster_boot_pkg::*;
#(
  parameter int NUM_CLUSTERS   = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int DELAY_W        = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [APB_DATA_WIDTH-1:0] pwdata_i,
  output logic [APB_DATA_WIDTH-1:0] prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  input  logic [NUM_CLUSTERS-1:0]   eoc_i,
  output logic [NUM_CLUSTERS-1:0]   cluster_rstn_o,
  output logic [NUM_CLUSTERS-1:0]   cluster_en_sa_boot_o,
  output logic [NUM_CLUSTERS-1:0]   cluster_fetch_en_o,
  output logic                      irq_o
);
  logic [8:0]                              addr;
  logic [NUM_CLUSTERS-1:0]                 sel_c, eoc_vec, irq_en_q;
  logic                                    sel_irq, mapped, wr_en, irq_q, autostart;
  lane_req_t [NUM_CLUSTERS-1:0]            req;
  lane_rsp_t [NUM_CLUSTERS-1:0]            rsp;
  logic [NUM_CLUSTERS-1:0][DELAY_W-1:0]    dly;
  logic [APB_DATA_WIDTH-1:0]               rdata;
  logic                                    unused_bits;

  assign addr        = paddr_i[8:0];
  assign wr_en       = psel_i & penable_i & pwrite_i;
  assign unused_bits = ^{paddr_i, pwdata_i};

  // Address decode: per-cluster windows at 0x10*c (CTRL/DELAY/STATUS), IRQ_EN at 0x100.
  always_comb begin
    sel_irq = (addr == 9'h100);
    sel_c   = '0;
    for (int c = 0; c < NUM_CLUSTERS; c++)
      sel_c[c] = ~addr[8] && (addr[7:4] == 4'(c)) && (addr[1:0] == 2'b00) &&
                 (addr[3:2] != 2'b11);
    mapped  = sel_irq | (|sel_c);
  end

  // Turn a committed write into per-lane register strobes.
  always_comb begin
    for (int c = 0; c < NUM_CLUSTERS; c++) begin
      req[c]          = '0;
      req[c].ctrl_wr  = wr_en & sel_c[c] & (addr[3:2] == 2'b00);
      req[c].start    = pwdata_i[0];
      req[c].stop     = pwdata_i[1];
      req[c].en_sa    = pwdata_i[2];
      req[c].delay_wr = wr_en & sel_c[c] & (addr[3:2] == 2'b01);
      req[c].eoc_clr  = wr_en & sel_c[c] & (addr[3:2] == 2'b10) & pwdata_i[4];
    end
  end

  // Read mux; unmapped addresses fall through to zero.
  always_comb begin
    rdata = '0;
    if (sel_irq) rdata = APB_DATA_WIDTH'(irq_en_q);
    for (int c = 0; c < NUM_CLUSTERS; c++) begin
      if (sel_c[c]) begin
        case (addr[3:2])
          2'b00: rdata[2] = rsp[c].en_sa;
          2'b01: rdata = APB_DATA_WIDTH'(dly[c]);
          2'b10: begin
            rdata[1:0] = rsp[c].state;
            rdata[4]   = rsp[c].eoc;
          end
          default: ;
        endcase
      end
    end
  end

  assign prdata_o  = psel_i ? rdata : '0;
  assign pready_o  = 1'b1;
  assign pslverr_o = psel_i & penable_i & ~mapped;

  // IRQ enable register and registered level interrupt.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en & sel_irq) irq_en_q <= pwdata_i[NUM_CLUSTERS-1:0];
      irq_q <= |(eoc_vec & irq_en_q);
    end
  end
  assign irq_o = irq_q;

`ifdef CLUSTER_BOOT_AUTOSTART_EN
  logic boot_done_q;
  // Emit a single START for cluster 0 on the first edge out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) boot_done_q <= 1'b0;
    else       boot_done_q <= 1'b1;
  end
  assign autostart = ~boot_done_q;
`else
  assign autostart = 1'b0;
`endif

  for (genvar c = 0; c < NUM_CLUSTERS; c++) begin : g_lane
    apb_cluster_boot_lane #(.DELAY_W(DELAY_W)) u_lane (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req[c]),
      .wdelay_i    (pwdata_i[DELAY_W-1:0]),
      .autostart_i ((c == 0) ? autostart : 1'b0),
      .eoc_i       (eoc_i[c]),
      .delay_o     (dly[c]),
      .rsp_o       (rsp[c]),
      .rstn_o      (cluster_rstn_o[c]),
      .fetch_en_o  (cluster_fetch_en_o[c]),
      .en_sa_boot_o(cluster_en_sa_boot_o[c])
    );
    assign eoc_vec[c] = rsp[c].eoc;
  end
endmodule
